// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer.
package timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // Per-channel control strobes after decode at the top level.
  typedef struct packed {
    logic cfg_we;
    logic start;
    logic stop;
    logic irq_clr;
  } ch_ctl_t;

  // Width of a channel index; never less than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: shadow/working period+mode, run state, count, tick, irq.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          CNT_WIDTH  = 30,
  parameter int unsigned RST_PERIOD = 1000000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ch_ctl_t              ctl,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic                 cfg_mode,
  output logic                 tick,
  output logic                 active,
  output logic                 irq_pending,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] RST_P = CNT_WIDTH'(RST_PERIOD);

  ch_state_t            state, state_nxt;
  logic [CNT_WIDTH-1:0] shd_period, wrk_period, count_nxt;
  logic                 shd_mode, wrk_mode;
  logic                 tick_nxt, reload;

  // Shadow registers: software-visible config, never touch the running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_period <= RST_P;
      shd_mode   <= MODE_PERIODIC;
    end else if (ctl.cfg_we) begin
      shd_period <= cfg_period;
      shd_mode   <= cfg_mode;
    end
  end

  // Next-state logic: stop beats start beats wrap beats increment.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tick_nxt  = 1'b0;
    reload    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctl.start && !ctl.stop) begin
          state_nxt = ST_RUN;
          count_nxt = '0;
          reload    = 1'b1;
        end
      end
      ST_RUN: begin
        if (ctl.stop) begin
          state_nxt = ST_IDLE;
        end else if (ctl.start) begin
          count_nxt = '0;
          reload    = 1'b1;
        end else if (count == wrk_period) begin
          tick_nxt  = 1'b1;
          count_nxt = '0;
          reload    = 1'b1;
          if (wrk_mode == MODE_ONESHOT) state_nxt = ST_IDLE;
        end else begin
          count_nxt = count + CNT_WIDTH'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, count, tick and working copy of the shadow config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      tick       <= 1'b0;
      wrk_period <= RST_P;
      wrk_mode   <= MODE_PERIODIC;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tick  <= tick_nxt;
      if (reload) begin
        wrk_period <= shd_period;
        wrk_mode   <= shd_mode;
      end
    end
  end

  // Sticky pending flag; a tick on the same edge as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              irq_pending <= 1'b0;
    else if (tick_nxt)    irq_pending <= 1'b1;
    else if (ctl.irq_clr) irq_pending <= 1'b0;
  end

  assign active = (state == ST_RUN);

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent programmable timers sharing one config write port.
module multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_WIDTH  = 30,
  parameter int unsigned RST_PERIOD = 1000000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]    cfg_ch,
  input  logic [CNT_WIDTH-1:0]           cfg_period,
  input  logic                           cfg_mode,
  input  logic [NUM_CH-1:0]              start,
  input  logic [NUM_CH-1:0]              stop,
  input  logic [NUM_CH-1:0]              irq_clr,
  output logic [NUM_CH-1:0]              tick,
  output logic [NUM_CH-1:0]              active,
  output logic [NUM_CH-1:0]              irq_pending,
  output logic [NUM_CH*CNT_WIDTH-1:0]    count
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  ch_ctl_t [NUM_CH-1:0]                ctl;
  logic    [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_arr;

  // Index decode only matches real channels, so out-of-range writes drop.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ctl[i].cfg_we  = cfg_we && (cfg_ch == IDX_W'(i));
    assign ctl[i].start   = start[i];
    assign ctl[i].stop    = stop[i];
    assign ctl[i].irq_clr = irq_clr[i];

    timer_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .ctl         (ctl[i]),
      .cfg_period  (cfg_period),
      .cfg_mode    (cfg_mode),
      .tick        (tick[i]),
      .active      (active[i]),
      .irq_pending (irq_pending[i]),
      .count       (cnt_arr[i])
    );
  end

  assign count = cnt_arr;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: small periods, checks sampled on negedge.
module tb_multi_timer;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic                clk, rst, cfg_we, cfg_mode;
  logic [1:0]          cfg_ch;
  logic [CW-1:0]       cfg_period;
  logic [NCH-1:0]      start, stop, irq_clr, tick, active, irq_pending;
  logic [NCH*CW-1:0]   count;
  logic [NCH-1:0][CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  assign cnt = count;

  multi_timer #(.NUM_CH(NCH), .CNT_WIDTH(CW), .RST_PERIOD(3)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start),
    .stop(stop), .irq_clr(irq_clr), .tick(tick), .active(active),
    .irq_pending(irq_pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CW-1:0] p, input logic m);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_mode = m;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_mode = 0;
    start = 0; stop = 0; irq_clr = 0;
    step(); step();
    chk("rst_tick", tick, 0);
    chk("rst_active", active, 0);
    chk("rst_irq", irq_pending, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    step();

    // Periodic, P=3 from reset value.
    start = 4'b0001; step(); start = 0;
    chk("p_start_active", active, 4'b0001);
    chk("p_start_cnt", cnt[0], 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("p_cnt", cnt[0], k);
      chk("p_notick", tick, 0);
    end
    step();
    chk("p_tick1", tick, 4'b0001);
    chk("p_irq1", irq_pending, 4'b0001);
    chk("p_wrap_cnt", cnt[0], 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("p_gap", tick, 0);
    end
    step();
    chk("p_tick2", tick, 4'b0001);

    // IRQ clear, then clear colliding with tick.
    irq_clr = 4'b0001; step(); irq_clr = 0;
    chk("irq_clr_alone", irq_pending[0], 1'b0);
    step(); step();
    chk("irq_pre_race_cnt", cnt[0], 3);
    irq_clr = 4'b0001; step(); irq_clr = 0;
    chk("irq_race_tick", tick[0], 1'b1);
    chk("irq_race_set", irq_pending[0], 1'b1);
    step();
    chk("irq_hold", irq_pending[0], 1'b1);
    irq_clr = 4'b0001; step(); irq_clr = 0;
    chk("irq_clr_later", irq_pending[0], 1'b0);
    stop = 4'b0001; step(); stop = 0;
    chk("stop0_active", active[0], 1'b0);
    chk("stop0_cnt", cnt[0], 2);

    // One-shot on channel 1, P=5.
    cfg(2'd1, 8'd5, 1'b1);
    start = 4'b0010; step(); start = 0;
    chk("os_active", active, 4'b0010);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("os_cnt", cnt[1], k);
      chk("os_notick", tick[1], 1'b0);
    end
    step();
    chk("os_tick", tick, 4'b0010);
    chk("os_active_drop", active[1], 1'b0);
    chk("os_cnt0", cnt[1], 0);
    chk("os_irq", irq_pending[1], 1'b1);
    step();
    chk("os_single", tick[1], 1'b0);
    chk("os_idle_cnt", cnt[1], 0);

    // Mid-run reprogram on channel 2: P=7, then P=2 written at count 3.
    cfg(2'd2, 8'd7, 1'b0);
    start = 4'b0100; step(); start = 0;
    step(); step(); step();
    chk("rp_cnt3", cnt[2], 3);
    cfg(2'd2, 8'd2, 1'b0);
    chk("rp_cnt4", cnt[2], 4);
    step(); step(); step();
    chk("rp_cnt7", cnt[2], 7);
    chk("rp_notick7", tick[2], 1'b0);
    step();
    chk("rp_tick_old", tick[2], 1'b1);
    for (int r = 0; r < 2; r++) begin
      step();
      chk("rp_new_c1", cnt[2], 1);
      step();
      chk("rp_new_c2", tick[2], 1'b0);
      step();
      chk("rp_new_tick", tick[2], 1'b1);
    end
    stop = 4'b0100; step(); stop = 0;
    chk("rp_stop", active[2], 1'b0);

    // Collisions on channel 3.
    start = 4'b1000; stop = 4'b1000; step(); start = 0; stop = 0;
    chk("col_idle", active[3], 1'b0);
    chk("col_idle_cnt", cnt[3], 0);
    cfg(2'd3, 8'd10, 1'b0);
    start = 4'b1000; step(); start = 0;
    step(); step(); step(); step();
    chk("col_cnt4", cnt[3], 4);
    stop = 4'b1000; step(); stop = 0;
    chk("col_stop_active", active[3], 1'b0);
    chk("col_stop_cnt", cnt[3], 4);
    chk("col_stop_tick", tick[3], 1'b0);
    step();
    chk("col_hold_cnt", cnt[3], 4);
    start = 4'b1000; step(); start = 0;
    chk("col_restart_active", active[3], 1'b1);
    chk("col_restart_cnt", cnt[3], 0);
    chk("col_restart_tick", tick[3], 1'b0);
    step(); step();
    chk("col_cnt2", cnt[3], 2);
    chk("col_pre_rst_irq", irq_pending, 4'b0110);

    // Async reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_active", active, 0);
    chk("ar_irq", irq_pending, 0);
    chk("ar_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Channel 3 should be back to P=3 periodic.
    start = 4'b1000; step(); start = 0;
    step(); step(); step();
    chk("ar_p3_cnt", cnt[3], 3);
    step();
    chk("ar_p3_tick", tick, 4'b1000);
    chk("ar_p3_periodic", active[3], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel successor to the single fixed-delay tick counter.
- NUM_CH independent timers, each with:
  - a run-time programmable period;
  - periodic or one-shot mode;
  - start/stop control;
  - a one-cycle tick pulse;
  - a sticky interrupt-pending flag.
- Sits between the board-level control logic and the LED/display or processor-side peripherals that need paced events.
- Replaces hard-coded DELAY instances.

Parameters:
- NUM_CH, 4: number of independent timer channels (1..16).
- CNT_WIDTH, 30: width of the period and count registers.
- RST_PERIOD, 1000000000: period value every channel holds after reset (synthesis value; benches override it small).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write strobe for the period of channel cfg_ch.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel select for the config write.
- cfg_period  input  CNT_WIDTH  new period value P.
- cfg_mode  input  1  mode written with the period: 0 = periodic, 1 = one-shot.
- start  input  NUM_CH  per-channel start/restart pulse.
- stop  input  NUM_CH  per-channel stop pulse.
- irq_clr  input  NUM_CH  per-channel clear of the pending flag.
- tick  output  NUM_CH  registered one-cycle pulse when a channel's count wraps.
- active  output  NUM_CH  channel is counting.
- irq_pending  output  NUM_CH  sticky flag, set by tick.
- count  output  NUM_CH*CNT_WIDTH  current count of each channel (channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]).

Behaviour:
- Reset (async, any time, including mid-count), per channel:
  - tick=0, active=0, irq_pending=0, count=0;
  - shadow period=RST_PERIOD, shadow mode=periodic;
  - working period=RST_PERIOD.
- Config write: on a clk edge with cfg_we=1, shadow period/mode of channel cfg_ch take cfg_period/cfg_mode.
  - An out-of-range cfg_ch (>= NUM_CH) is ignored.
  - Writes never disturb a running count.
- Working period/mode are copied from the shadow:
  - on start;
  - at every wrap.
  - A write during a periodic run therefore takes effect from the next period.
- Channel states: IDLE (active=0) and RUN (active=1).
- IDLE:
  - start=1 -> RUN, count<=0, working regs <= shadow.
  - Otherwise count holds.
- RUN, evaluated each edge in this priority:
  1. stop=1 -> IDLE, count holds its value, no tick.
  2. start=1 -> restart: count<=0, working regs reloaded, no tick, stays RUN.
  3. count==working period -> tick<=1, count<=0, working regs reloaded from shadow. Periodic mode stays RUN; one-shot mode goes to IDLE.
  4. Else count<=count+1, tick<=0.
- tick is 0 on every edge where rule 3 does not fire.
- Timing: with start sampled at edge 0 and period P, tick is high during the cycle after edge P+1.
  - Periodic mode then repeats every P+1 cycles.
  - P=0 in periodic mode gives tick held high continuously (one pulse per cycle).
- Simultaneous start and stop on a channel: stop wins, including from IDLE (the channel stays IDLE).
- irq_pending:
  - set on the edge that asserts tick;
  - cleared by irq_clr;
  - when tick-set and irq_clr occur together, set wins.
- Arithmetic: count never exceeds the working period, so no overflow wrap is possible. The comparison is unsigned equality at full CNT_WIDTH.
- Channels are fully independent; cfg and control for channel i never affect channel j.

Decomposition:
- Package timer_pkg holds:
  - MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1;
  - the channel state encoding (ST_IDLE, ST_RUN);
  - a helper function for the channel index width.
- Sub-module timer_channel implements one channel: shadow regs, working regs, state, count, tick, irq.
- multi_timer:
  - decodes cfg_we/cfg_ch into per-channel write enables;
  - instantiates NUM_CH copies of timer_channel in a generate loop;
  - packs count.

Test Plan:
- Reset, periodic tick:
  - Stimulus: RST_PERIOD=3; start[0] pulsed one cycle after reset release.
  - Response: tick[0] high once every 4 cycles, first pulse 4 edges after start; irq_pending[0]=1 after the first tick; other channels silent.
- One-shot:
  - Stimulus: cfg_ch=1, cfg_period=5, cfg_mode=1, then start[1].
  - Response: exactly one tick[1] 6 edges after start; active[1] drops on the same edge as the tick; count[1]=0 afterwards.
- Mid-run reprogram:
  - Stimulus: channel 2 running with P=7; write P=2 at count=3.
  - Response: the current period still ticks at count 7; subsequent ticks every 3 cycles.
- Control collisions:
  - Stimulus: start and stop together on an idle channel; then, on a running channel, stop at count=4 followed by start.
  - Response: the idle channel stays idle; the running channel stops with count held at 4; start restarts it from 0; no spurious tick.
- IRQ race:
  - Stimulus: assert irq_clr[0] on the same edge tick[0] is generated.
  - Response: irq_pending[0] remains 1; a later irq_clr alone clears it.
- Async reset mid-count:
  - Stimulus: assert rst between clock edges at count=2.
  - Response: all outputs go to 0 immediately, without a clk edge; after release, period is back to RST_PERIOD and mode to periodic.
